// File: rtl/alu_exec_pkg.sv
// Shared types and encodings for the ALU execution unit: operation enum, AluOp/funct codes,
// FSM state encoding.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OpAdd,
    OpSub,
    OpAnd,
    OpOr,
    OpXor,
    OpNor,
    OpSlt,
    OpSll,
    OpSrl,
    OpMultu,
    OpIllegal
  } alu_op_t;

  localparam logic [3:0] AluOpRtype = 4'b0000;
  localparam logic [3:0] AluOpAdd   = 4'b0001;
  localparam logic [3:0] AluOpSub   = 4'b0010;
  localparam logic [3:0] AluOpAnd   = 4'b0011;
  localparam logic [3:0] AluOpOr    = 4'b0100;
  localparam logic [3:0] AluOpSlt   = 4'b0101;

  localparam logic [5:0] FnAdd   = 6'b100000;
  localparam logic [5:0] FnSub   = 6'b100010;
  localparam logic [5:0] FnAnd   = 6'b100100;
  localparam logic [5:0] FnOr    = 6'b100101;
  localparam logic [5:0] FnXor   = 6'b100110;
  localparam logic [5:0] FnNor   = 6'b100111;
  localparam logic [5:0] FnSlt   = 6'b101010;
  localparam logic [5:0] FnSll   = 6'b000000;
  localparam logic [5:0] FnSrl   = 6'b000010;
  localparam logic [5:0] FnMultu = 6'b011001;

  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StMul  = 1'b1;

  function automatic logic is_multi_cycle(alu_op_t op);
    return op == OpMultu;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Operation/result handshake bundle of the ALU execution unit.
// The ovf signal exists only when ALU_OVF_FLAG_EN is defined.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [5:0]       func;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             illegal;
`ifdef ALU_OVF_FLAG_EN
  logic             ovf;

  modport master (
    output in_valid, alu_op, func, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, illegal, ovf
  );

  modport slave (
    input  in_valid, alu_op, func, op_a, op_b, out_ready,
    output in_ready, out_valid, result, result_hi, zero, illegal, ovf
  );
`else
  modport master (
    output in_valid, alu_op, func, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, result_hi, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, func, op_a, op_b, out_ready,
    output in_ready, out_valid, result, result_hi, zero, illegal
  );
`endif

endinterface

// File: rtl/alu_op_decode.sv
// Combinational AluOp/funct decoder producing the internal operation code.
module alu_op_decode
  import alu_exec_pkg::*;
(
  input  logic [3:0] alu_op,
  input  logic [5:0] func,
  output alu_op_t    op
);

  always_comb begin
    op = OpIllegal;
    case (alu_op)
      AluOpRtype: begin
        case (func)
          FnAdd:   op = OpAdd;
          FnSub:   op = OpSub;
          FnAnd:   op = OpAnd;
          FnOr:    op = OpOr;
          FnXor:   op = OpXor;
          FnNor:   op = OpNor;
          FnSlt:   op = OpSlt;
          FnSll:   op = OpSll;
          FnSrl:   op = OpSrl;
          FnMultu: op = OpMultu;
          default: op = OpIllegal;
        endcase
      end
      AluOpAdd: op = OpAdd;
      AluOpSub: op = OpSub;
      AluOpAnd: op = OpAnd;
      AluOpOr:  op = OpOr;
      AluOpSlt: op = OpSlt;
      default:  op = OpIllegal;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU execution unit: single-cycle ops plus a WIDTH-cycle shift-add MULTU.
// Define ALU_OVF_FLAG_EN to add the signed-overflow flag output (bus.ovf).
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;

  alu_op_t dec_op;

  alu_op_decode u_decode (
    .alu_op (bus.alu_op),
    .func   (bus.func),
    .op     (dec_op)
  );

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic               out_valid_q, out_valid_d;

  logic               in_ready;
  logic               xfer;
  logic               mul_last;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [PW-1:0]      mul_next;

  assign shamt = bus.op_b[SHAMT_W-1:0];
  assign sum   = bus.op_a + bus.op_b;
  assign diff  = bus.op_a - bus.op_b;

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OpAdd:   alu_res = sum;
      OpSub:   alu_res = diff;
      OpAnd:   alu_res = bus.op_a & bus.op_b;
      OpOr:    alu_res = bus.op_a | bus.op_b;
      OpXor:   alu_res = bus.op_a ^ bus.op_b;
      OpNor:   alu_res = ~(bus.op_a | bus.op_b);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      OpSll:   alu_res = bus.op_a << shamt;
      OpSrl:   alu_res = bus.op_a >> shamt;
      default: alu_res = '0;
    endcase
  end

  // prod_q holds {partial high, remaining multiplier}; each step adds the multiplicand on the
  // multiplier LSB and shifts the whole thing right by one, carry included.
  assign mul_sum  = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_last = (cnt_q == SHAMT_W'(WIDTH - 1));

  assign in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign xfer     = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;

    case (state_q)
      StIdle: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
        end
        if (xfer) begin
          if (is_multi_cycle(dec_op)) begin
            state_d     = StMul;
            cnt_d       = '0;
            mcand_d     = bus.op_a;
            prod_d      = {{WIDTH{1'b0}}, bus.op_b};
            out_valid_d = 1'b0;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            illegal_d   = (dec_op == OpIllegal);
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + SHAMT_W'(1);
        if (mul_last) begin
          state_d     = StIdle;
          result_d    = mul_next[WIDTH-1:0];
          result_hi_d = mul_next[PW-1:WIDTH];
          zero_d      = (mul_next[WIDTH-1:0] == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ALU_OVF_FLAG_EN
  logic ovf_q, ovf_d, alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    if (dec_op == OpAdd) begin
      alu_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) && (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
    end else if (dec_op == OpSub) begin
      alu_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) && (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
    end
    ovf_d = ovf_q;
    if (xfer) begin
      ovf_d = alu_ovf;
    end else if (state_q == StMul && mul_last) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: single-cycle ops, MULTU latency, backpressure,
// back-to-back throughput, illegal decode and reset during a multiply.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(16)) bus ();

  alu_exec_unit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] aop, input logic [5:0] fn,
                       input logic [15:0] a, input logic [15:0] b);
    bus.alu_op = aop;
    bus.func   = fn;
    bus.op_a   = a;
    bus.op_b   = b;
  endtask

  task automatic run_op(input string tag, input logic [3:0] aop, input logic [5:0] fn,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic exp_ill, input logic exp_ovf);
    @(negedge clk);
    check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    drive(aop, fn, a, b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, ".result"}, 32'(bus.result), 32'(exp_res));
    check_eq({tag, ".result_hi"}, 32'(bus.result_hi), 32'd0);
    check_eq({tag, ".illegal"}, 32'(bus.illegal), 32'(exp_ill));
    if (!exp_ill) begin
      check_eq({tag, ".zero"}, 32'(bus.zero), 32'(exp_res == 16'h0000));
    end
`ifdef ALU_OVF_FLAG_EN
    check_eq({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
    if (exp_ovf) begin
    end
`endif
  endtask

  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_prod);
    int   lat;
    logic rdy_seen;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    drive(4'b0000, 6'b011001, a, b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    // Operands must have been latched at accept.
    drive(4'b0000, 6'b100000, 16'h0000, 16'h0000);
    lat      = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      rdy_seen = rdy_seen | bus.in_ready;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, ".latency"}, 32'(lat), 32'd16);
    check_eq({tag, ".busy_ready"}, 32'(rdy_seen), 32'd0);
    check_eq({tag, ".result_hi"}, 32'(bus.result_hi), 32'(exp_prod[31:16]));
    check_eq({tag, ".result"}, 32'(bus.result), 32'(exp_prod[15:0]));
    check_eq({tag, ".illegal"}, 32'(bus.illegal), 32'd0);
  endtask

  logic [3:0]  b2b_aop [4] = '{4'b0000, 4'b0010, 4'b0100, 4'b0000};
  logic [5:0]  b2b_fn  [4] = '{6'b100000, 6'b000000, 6'b000000, 6'b100110};
  logic [15:0] b2b_a   [4] = '{16'h0001, 16'h0010, 16'h00F0, 16'h1111};
  logic [15:0] b2b_b   [4] = '{16'h0002, 16'h0003, 16'h0F00, 16'h0101};
  logic [15:0] b2b_exp [4] = '{16'h0003, 16'h000D, 16'h0FF0, 16'h1010};

  initial begin
    logic seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'b0000, 6'b000000, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("reset.result", 32'(bus.result), 32'd0);
    check_eq("reset.result_hi", 32'(bus.result_hi), 32'd0);
    check_eq("reset.zero", 32'(bus.zero), 32'd0);
    check_eq("reset.illegal", 32'(bus.illegal), 32'd0);
    check_eq("reset.in_ready", 32'(bus.in_ready), 32'd1);

    run_op("add_r",  4'b0000, 6'b100000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run_op("sub",    4'b0010, 6'b000000, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);
    run_op("sub_ov", 4'b0010, 6'b000000, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    run_op("slt",    4'b0101, 6'b000000, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0);
    run_op("slt_r",  4'b0000, 6'b101010, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    run_op("sll",    4'b0000, 6'b000000, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0);
    run_op("srl",    4'b0000, 6'b000010, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0);
    run_op("and",    4'b0011, 6'b000000, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
    run_op("or",     4'b0100, 6'b000000, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0);
    run_op("xor_r",  4'b0000, 6'b100110, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0);
    run_op("nor_r",  4'b0000, 6'b100111, 16'h0F0F, 16'h00F0, 16'hF000, 1'b0, 1'b0);
    run_op("ill_op", 4'b0111, 6'b100000, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0);
    run_op("ill_fn", 4'b0000, 6'b111111, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);

    run_mul("mul_ff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run_mul("mul_mix", 16'h1234, 16'h5678, 32'h0626_0060);

    // Backpressure: hold an ADD result for 5 cycles.
    @(negedge clk);
    drive(4'b0000, 6'b100000, 16'h0100, 16'h0023);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_eq("hold.out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold.result", 32'(bus.result), 32'h0123);
      check_eq("hold.in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end

    // Back-to-back: consumer drains the held result while new ops stream in.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(b2b_aop[i], b2b_fn[i], b2b_a[i], b2b_b[i]);
      bus.in_valid = 1'b1;
      #1;
      check_eq("b2b.in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      check_eq("b2b.out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("b2b.result", 32'(bus.result), 32'(b2b_exp[i]));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("drain.out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("drain.result", 32'(bus.result), 32'h1010);

    // Reset during a multiply discards it.
    drive(4'b0000, 6'b011001, 16'h1234, 16'h5678);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("mrst.out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mrst.result", 32'(bus.result), 32'd0);
    check_eq("mrst.result_hi", 32'(bus.result_hi), 32'd0);
    check_eq("mrst.in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check_eq("mrst.no_valid", 32'(seen), 32'd0);
    run_mul("mul_post", 16'h0003, 16'h0005, 32'h0000_000F);
    run_mul("mul_post2", 16'h1234, 16'h5678, 32'h0626_0060);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
